// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS pipeline stage registers: reset PC, NOP encoding,
// control-bundle layout and the hazard-control legality check.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          CTRL_W           = 8;

    // Control bundle layout: {RegWrite, MemtoReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst}
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_ALU_MSB  = 4;
    localparam int CTRL_ALU_LSB  = 2;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_REGDST   = 0;

    // A stalled decode stage must stall fetch too and bubble execute, or an
    // instruction gets duplicated/lost.
    function automatic logic proto_violation(input logic stall_f, input logic stall_d,
                                             input logic flush_e);
        return (stall_f != stall_d) || (stall_d && !flush_e);
    endfunction

endpackage

// File: rtl/pipe_stage_regs_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// Fetch PC, IF/ID and ID/EX registers driven by the hazard unit, with event
// counters and a sticky flag for illegal stall/flush combinations.
module pipe_stage_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CTRL_W   = pipe_pkg::CTRL_W,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushE,
    input  logic              PCSrcD,
    input  logic [31:0]       PCBranchD,
    input  logic [31:0]       InstrF,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [4:0]        RsD,
    input  logic [4:0]        RtD,
    input  logic [4:0]        RdD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       SignImmD,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCPlus4D,
    output logic              ValidD,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [4:0]        RsE,
    output logic [4:0]        RtE,
    output logic [4:0]        RdE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       SignImmE,
    output logic              ValidE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  SquashCnt,
    output logic [CNT_W-1:0]  BubbleCnt,
    output logic              ProtoErr
);

    logic [31:0]       pcf_q, pcf_d;
    logic [31:0]       instrd_q, instrd_d;
    logic [31:0]       pcplus4d_q, pcplus4d_d;
    logic              validd_q, validd_d;
    logic [CTRL_W-1:0] ctrle_q, ctrle_d;
    logic [4:0]        rse_q, rse_d, rte_q, rte_d, rde_q, rde_d;
    logic [31:0]       rd1e_q, rd1e_d, rd2e_q, rd2e_d, imme_q, imme_d;
    logic              valide_q, valide_d;
    logic              proto_err_q, proto_err_d;
    logic [31:0]       pc_plus4;

    assign pc_plus4 = pcf_q + 32'd4;

    always_comb begin
        pcf_d       = pcf_q;
        instrd_d    = instrd_q;
        pcplus4d_d  = pcplus4d_q;
        validd_d    = validd_q;
        proto_err_d = proto_err_q | proto_violation(StallF, StallD, FlushE);

        if (!StallF) begin
            pcf_d = PCSrcD ? PCBranchD : pc_plus4;
        end

        if (!StallD) begin
            if (PCSrcD) begin
                instrd_d   = NOP_INSTR;
                pcplus4d_d = '0;
                validd_d   = 1'b0;
            end else begin
                instrd_d   = InstrF;
                pcplus4d_d = pc_plus4;
                validd_d   = 1'b1;
            end
        end

        // ID/EX never holds: it takes D or a fully zeroed bubble every cycle,
        // so a bubble's register fields cannot match a forwarding comparator.
        if (FlushE) begin
            ctrle_d  = '0;
            rse_d    = '0;
            rte_d    = '0;
            rde_d    = '0;
            rd1e_d   = '0;
            rd2e_d   = '0;
            imme_d   = '0;
            valide_d = 1'b0;
        end else begin
            ctrle_d  = CtrlD;
            rse_d    = RsD;
            rte_d    = RtD;
            rde_d    = RdD;
            rd1e_d   = RD1D;
            rd2e_d   = RD2D;
            imme_d   = SignImmD;
            valide_d = validd_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcf_q       <= RESET_PC;
            instrd_q    <= '0;
            pcplus4d_q  <= '0;
            validd_q    <= 1'b0;
            ctrle_q     <= '0;
            rse_q       <= '0;
            rte_q       <= '0;
            rde_q       <= '0;
            rd1e_q      <= '0;
            rd2e_q      <= '0;
            imme_q      <= '0;
            valide_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pcf_q       <= pcf_d;
            instrd_q    <= instrd_d;
            pcplus4d_q  <= pcplus4d_d;
            validd_q    <= validd_d;
            ctrle_q     <= ctrle_d;
            rse_q       <= rse_d;
            rte_q       <= rte_d;
            rde_q       <= rde_d;
            rd1e_q      <= rd1e_d;
            rd2e_q      <= rd2e_d;
            imme_q      <= imme_d;
            valide_q    <= valide_d;
            proto_err_q <= proto_err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (StallD),
        .cnt_o (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_squash_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (PCSrcD && !StallD),
        .cnt_o (SquashCnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (FlushE),
        .cnt_o (BubbleCnt)
    );

    assign PCF      = pcf_q;
    assign InstrD   = instrd_q;
    assign PCPlus4D = pcplus4d_q;
    assign ValidD   = validd_q;
    assign CtrlE    = ctrle_q;
    assign RsE      = rse_q;
    assign RtE      = rte_q;
    assign RdE      = rde_q;
    assign RD1E     = rd1e_q;
    assign RD2E     = rd2e_q;
    assign SignImmE = imme_q;
    assign ValidE   = valide_q;
    assign ProtoErr = proto_err_q;

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Consumer end of the hazard-control interface in the 5-stage MIPS pipeline.
- Holds the fetch PC, the IF/ID register and the ID/EX register, and applies StallF, StallD, FlushE and PCSrcD to them.
- Tracks per-stage valid bits, counts stall, squash and bubble events, and flags protocol violations on the hazard-control inputs.
- Sits between the fetch/decode datapath and the execute stage; its E-stage outputs feed the hazard unit and the ALU.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- CTRL_W, 8, width of the decode control bundle (RegWrite, MemtoReg, MemWrite, ALUControl, ALUSrc, RegDst).
- CNT_W, 16, width of the event counters.

Ports:
- clk in 1: single clock, rising edge.
- rst in 1: asynchronous active-low reset.
- StallF in 1: hold PC.
- StallD in 1: hold IF/ID.
- FlushE in 1: insert bubble into ID/EX.
- PCSrcD in 1: branch taken in D; squash IF/ID.
- PCBranchD in 32: branch target.
- InstrF in 32: instruction memory read data.
- CtrlD in CTRL_W: decoded control.
- RsD, RtD, RdD in 5 each: register fields.
- RD1D, RD2D, SignImmD in 32 each: operands.
- PCF out 32: fetch PC.
- InstrD out 32.
- PCPlus4D out 32.
- ValidD out 1.
- CtrlE out CTRL_W.
- RsE, RtE, RdE out 5 each.
- RD1E, RD2E, SignImmE out 32 each.
- ValidE out 1.
- StallCnt, SquashCnt, BubbleCnt out CNT_W each.
- ProtoErr out 1: sticky protocol-violation flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - PCF=RESET_PC.
  - All D and E registers=0, including ValidD and ValidE.
  - Counters=0; ProtoErr=0.
  - Reset asserted mid-stall or mid-flush discards all in-flight state.
- PC register, updated every rising clk:
  - StallF=1: hold.
  - Else PCSrcD=1: PCF<=PCBranchD.
  - Else PCF<=PCF+4 (mod 2^32, wrap silently).
  - StallF has priority over PCSrcD.
- IF/ID register, priority order:
  - StallD=1: hold all fields.
  - Else PCSrcD=1: InstrD<=0 (NOP), PCPlus4D<=0, ValidD<=0.
  - Else load: InstrD<=InstrF, PCPlus4D<=PCF+4, ValidD<=1.
- ID/EX register:
  - FlushE=1: CtrlE<=0, RsE/RtE/RdE<=0, RD1E/RD2E/SignImmE<=0, ValidE<=0. Zeroed register fields guarantee no false forwarding matches.
  - Else load all fields from D; ValidE<=ValidD.
  - ID/EX has no stall input; it loads or flushes every cycle.
- Latency: one cycle per stage; an instruction presented on InstrF at edge N appears on InstrD after edge N and on E outputs after edge N+1, absent stalls.
- Counters, all saturating at all-ones (no wrap):
  - StallCnt +1 each cycle StallD=1.
  - SquashCnt +1 each cycle PCSrcD=1 and StallD=0.
  - BubbleCnt +1 each cycle FlushE=1.
  - Simultaneous events increment each affected counter in the same cycle.
- ProtoErr:
  - Set on any edge where StallF!=StallD, or where StallD=1 and FlushE=0 (stalled D would duplicate an instruction into E).
  - Sticky; cleared only by reset.
  - Pipeline behaviour is unchanged by an error; the flag is report-only.
- All outputs are registered; no combinational input-to-output paths except through clocked state.

Decomposition:
- Shared package pipe_pkg holds:
  - RESET_PC_DEFAULT.
  - NOP_INSTR=32'h0.
  - Control-bundle bit positions (CTRL_REGWRITE, CTRL_MEMTOREG, ...).
  - CTRL_W.
- One natural sub-module, sat_counter (width CNT_W, inc input, saturating), instantiated three times.

Test Plan:
- Reset then 4 free-running cycles, InstrF=0x20080005..: PCF=0,4,8,12; InstrD tracks with 1-cycle lag, ValidD=1; E fields lag D by one cycle, ValidE=1.
- Load-use stall, StallF=StallD=FlushE=1 for 1 cycle at PCF=8: PCF holds 8; InstrD holds; ValidE=0 and RsE/RtE=0 next cycle; StallCnt=1, BubbleCnt=1, ProtoErr=0.
- Branch taken, PCSrcD=1, PCBranchD=0x40, no stall: PCF=0x40 next cycle; InstrD=0 with ValidD=0; SquashCnt=1.
- Branch stall coinciding with PCSrcD=1 plus all stalls asserted: PCF and IF/ID hold, no squash, SquashCnt unchanged; PC redirects on the first cycle the stall drops.
- Protocol violation, StallD=1 with StallF=0: ProtoErr=1 and stays 1 after inputs return legal; cleared only by pulsing rst=0.
- Saturation with CNT_W=4 override, StallD/StallF/FlushE held 20 cycles: StallCnt=BubbleCnt=4'hF; async rst asserted mid-stall zeros all state immediately without a clock edge.
